// File: rtl/rx_pkg.sv
// Shared receiver/transmitter definitions: default sizes, clog2 and packed-bus lane slicing.
package rx_pkg;

  localparam int DEF_SYM_W   = 9;
  localparam int DEF_N_LANES = 7;
  localparam int DEF_REPS    = 3;
  localparam int MAX_BUS     = 1024;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Lane 'lane' of a bus packed as lane k at [k*w +: w]; w must be below 32.
  function automatic logic [31:0] lane_slice(input logic [MAX_BUS-1:0] bus,
                                             input int lane, input int w);
    logic [MAX_BUS-1:0] sh;
    sh = bus >> (lane * w);
    return sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/rep_combine_rx_lane_acc.sv
// One lane of the repetition combiner: running sum plus decision/erasure on the
// sum that would result from accepting the current symbol.
module lane_acc
  import rx_pkg::*;
#(
  parameter int               SYM_W  = DEF_SYM_W,
  parameter int               ACC_W  = DEF_SYM_W + 2,
  parameter logic [ACC_W-1:0] TGT    = '0,
  parameter int               MARGIN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [SYM_W-1:0] sym_i,
  output logic             decide_o,
  output logic             erase_o
);

  logic [ACC_W-1:0]        acc_q, sum;
  logic signed [ACC_W:0]   diff;
  logic [ACC_W:0]          mag;

  assign sum  = acc_q + ACC_W'(sym_i);
  assign diff = $signed({1'b0, sum}) - $signed({1'b0, TGT});
  assign mag  = diff[ACC_W] ? $unsigned(-diff) : $unsigned(diff);

  // Ties decode to 1; MARGIN of 0 can never be undercut, so erasures vanish.
  assign decide_o = (sum >= TGT);
  assign erase_o  = (mag < (ACC_W+1)'(MARGIN));

  always_ff @(posedge clk) begin
    if (reset)      acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i)  acc_q <= sum;
  end

endmodule

// File: rtl/rep_combine_rx.sv
// Repetition-combining receiver: sums REPS beats per lane, then slices against
// REPS*THRESH and flags near-threshold lanes as erasures.
module rep_combine_rx
  import rx_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int SYM_W   = DEF_SYM_W,
  parameter int REPS    = DEF_REPS,
  parameter int THRESH  = 2 ** (SYM_W - 1),
  parameter int MARGIN  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_LANES*SYM_W-1:0] in_sym,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_LANES-1:0]       out_data,
  output logic [N_LANES-1:0]       out_erase,
  output logic [15:0]              out_words
);

  localparam int               ACC_W = SYM_W + clog2(REPS + 1);
  localparam logic [ACC_W-1:0] TGT   = ACC_W'(REPS * THRESH);

  localparam logic [0:0] S_ACCUM  = 1'b0;
  localparam logic [0:0] S_OUTPUT = 1'b1;

  logic [0:0]                    state_q, state_d;
  logic [3:0]                    cnt_q, cnt_d;
  logic [N_LANES-1:0]            data_q, data_d, erase_q, erase_d;
  logic [15:0]                   words_q, words_d;
  logic [N_LANES-1:0][SYM_W-1:0] sym;
  logic [N_LANES-1:0]            lane_dec, lane_ers;
  logic                          accept, last;

  assign accept = in_valid && (state_q == S_ACCUM);
  assign last   = accept && (cnt_q == 4'(REPS - 1));

  for (genvar k = 0; k < N_LANES; k++) begin : gen_lane
    assign sym[k] = SYM_W'(lane_slice(MAX_BUS'(in_sym), k, SYM_W));

    lane_acc #(
      .SYM_W (SYM_W),
      .ACC_W (ACC_W),
      .TGT   (TGT),
      .MARGIN(MARGIN)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (last),
      .en_i    (accept),
      .sym_i   (sym[k]),
      .decide_o(lane_dec[k]),
      .erase_o (lane_ers[k])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    erase_d = erase_q;
    words_d = words_q;
    case (state_q)
      S_ACCUM: begin
        if (last) begin
          data_d  = lane_dec;
          erase_d = lane_ers;
          cnt_d   = '0;
          state_d = S_OUTPUT;
        end else if (accept) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          words_d = words_q + 16'd1;
          state_d = S_ACCUM;
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ACCUM;
      cnt_q   <= '0;
      data_q  <= '0;
      erase_q <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      erase_q <= erase_d;
      words_q <= words_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUTPUT);
  assign out_data  = data_q;
  assign out_erase = erase_q;
  assign out_words = words_q;

endmodule

// File: doc/rep_combine_rx.md
Name: rep_combine_rx

Overview:
- Parametrised successor to the single-sample MSB slicer receiver.
- Accepts N_LANES noisy unsigned symbols per beat over a valid/ready handshake and accumulates REPS repeated beats per lane.
- Makes a hard decision per lane against a scaled threshold, and flags low-confidence lanes as erasures.
- Sits between the noisy channel adder and the data sink, replacing the per-bit MSB tap.

Parameters:
- N_LANES, 7, number of bit lanes per word.
- SYM_W, 9, width of each unsigned channel symbol.
- REPS, 3, beats combined per decision (legal 1..15).
- THRESH, 256, per-sample decision threshold; symbol >= THRESH reads as 1 (default 2^(SYM_W-1)).
- MARGIN, 0, erasure half-window on the accumulated sum; 0 disables erasures.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_sym holds a valid beat.
- in_ready  out  1  block accepts a beat this cycle.
- in_sym  in  N_LANES*SYM_W  lane k occupies bits [k*SYM_W +: SYM_W].
- out_valid  out  1  decision word available.
- out_ready  in  1  sink accepts the word.
- out_data  out  N_LANES  hard decision per lane, lane 0 = bit 0.
- out_erase  out  N_LANES  per-lane erasure flag.
- out_words  out  16  count of words handed off; wraps at 65535->0.

Behaviour:
- Localparams:
  - ACC_W = SYM_W + clog2(REPS+1).
  - TGT = REPS*THRESH, computed at ACC_W width.
- State machine, two states:
  - ACCUM:
    - in_ready=1, out_valid=0.
    - Beat accepted when in_valid && in_ready: each lane acc += zero-extended symbol; beat_cnt += 1.
    - On accepting the beat with beat_cnt==REPS-1, per lane: out_data[k] = (acc_k + sym_k >= TGT); out_erase[k] = (|acc_k + sym_k - TGT| < MARGIN).
    - That same edge registers the outputs, clears acc and beat_cnt, and moves to OUTPUT.
  - OUTPUT:
    - out_valid=1, in_ready=0.
    - out_data/out_erase stay stable until the handshake.
    - On out_ready=1: out_words += 1, go to ACCUM, out_valid drops next cycle.
- Latency: out_valid rises the cycle after the REPS-th accepted beat.
- Throughput: at most one word per REPS+1 cycles.
- in_valid=0 during ACCUM: hold acc and beat_cnt; gaps between beats are legal.
- out_ready held low: stay in OUTPUT indefinitely; in_sym is ignored.
- REPS=1 degenerates to a registered single-sample slicer; with THRESH=2^(SYM_W-1) the result equals the symbol MSB.
- Arithmetic:
  - Sums are unsigned and cannot overflow: REPS*(2^SYM_W-1) fits ACC_W.
  - Erasure distance uses ACC_W+1-bit signed difference.
  - out_data ties (sum == TGT) decode to 1.
- Reset (any cycle, including mid-accumulation or while holding OUTPUT):
  - state=ACCUM, acc=0, beat_cnt=0.
  - out_valid=0, out_data=0, out_erase=0, out_words=0.
  - in_ready=1 the cycle after reset deasserts.
  - Partial accumulations are discarded.

Decomposition:
- Shared package rx_pkg holds:
  - Constant function clog2.
  - Default constants DEF_SYM_W=9, DEF_N_LANES=7, DEF_REPS=3.
  - The lane-slice helper for packed symbol buses, reused by the transmitter side.
- One sub-module, lane_acc:
  - One lane accumulator with clear/enable.
  - Combinational decide and erase outputs against TGT/MARGIN.
  - Instantiated N_LANES times via generate.
- FSM, beat counter and word counter live in the top.

Test Plan:
- Defaults. Three beats with all lanes = 300, in_valid held high:
  - out_valid rises on cycle 4 with out_data=7'h7F, out_erase=0.
  - in_ready stays low until out_ready.
- Mixed per-lane values across beats; lane 0 = 200, 300, 268 (sum 768):
  - Tie case, out_data[0]=1.
  - Lane 1 = 255, 255, 257 (sum 767) gives out_data[1]=0.
- MARGIN=16. Lane 0 sum 760 -> out_erase[0]=1; lane 0 sum 800 -> out_erase[0]=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles: out_data stable, in_ready=0, no beats consumed.
  - Release: out_words 0->1, next word accumulates fresh.
- Reset after 2 of 3 beats: out_valid=0, out_words=0.
  - Then 3 new beats all lanes = 100 -> out_data=7'h00, proving the partial sum was discarded.
- REPS=1, SYM_W=9, 20 random symbols: out_data equals the MSB of each lane of the accepted symbol, one cycle late; out_words reaches 20.
